// File: rtl/rca_pkg.sv
// Shared types and default widths for the ripple-carry accumulator slice.
package rca_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    localparam int RCA_WIDTH = 32;
    localparam int RCA_CNT_W = 8;

endpackage

// File: rtl/rca.sv
// Combinational ripple-carry adder: s = a + b + cin, with the carry-out in s[WIDTH].
module rca
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   s
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign s[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign s[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/rca_accumulator.sv
// Packet accumulator: sums a valid/ready operand stream through rca and holds the
// total, sticky carry flag and beat count until the consumer takes it.
module rca_accumulator
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH,
    parameter int CNT_W = RCA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    acc_state_t       state;
    acc_state_t       state_next;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic [CNT_W-1:0] count;
    logic             trunc;
    logic [WIDTH:0]   s;
    logic             accept;
    logic [CNT_W-1:0] count_inc;
    logic             sat;

    rca #(.WIDTH(WIDTH)) u_rca (
        .a  (acc),
        .b  (in_data),
        .cin(1'b0),
        .s  (s)
    );

    // Handshake flags come from state alone, so no input reaches in_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign count_inc = count + 1'b1;
    assign sat       = (count_inc == {CNT_W{1'b1}});

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && (in_last || sat)) state_next = HOLD;
            HOLD:  if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            trunc <= 1'b0;
        end else if (accept) begin
            acc   <= s[WIDTH-1:0];
            ovf   <= ovf | s[WIDTH];
            count <= count_inc;
            // Only meaningful on the closing beat; earlier beats leave it at 0.
            trunc <= ~in_last & sat;
        end else if (out_valid && out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
            trunc <= 1'b0;
        end
    end

    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = count;
    assign out_trunc = trunc;

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed and randomized-gap bench for rca_accumulator (WIDTH=32, CNT_W=3).
module tb_rca_accumulator;

    localparam int WIDTH = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;
    logic             out_trunc;

    int checks = 0;
    int errors = 0;

    rca_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .out_count(out_count),
        .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [31:0] sum, input logic ovf,
                              input logic [2:0] cnt, input logic trunc);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_sum"}, {32'd0, out_sum}, {32'd0, sum});
        chk({tag, "_ovf"}, {63'd0, out_ovf}, {63'd0, ovf});
        chk({tag, "_count"}, {61'd0, out_count}, {61'd0, cnt});
        chk({tag, "_trunc"}, {63'd0, out_trunc}, {63'd0, trunc});
    endtask

    // Drive one beat and return #1 after the edge that accepted it.
    task automatic send(input logic [31:0] d, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) chk("send_timeout", {63'd0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] m_acc;
        logic        m_ovf;
        logic [2:0]  m_cnt;
        logic [32:0] wide;
        logic [31:0] d;
        logic        last;
        int          len;
        int          gap;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_sum", {32'd0, out_sum}, 64'd0);
        chk("rst_count", {61'd0, out_count}, 64'd0);
        chk("rst_ovf", {63'd0, out_ovf}, 64'd0);
        chk("rst_trunc", {63'd0, out_trunc}, 64'd0);

        // 5 + 7 + 9 with out_ready already high
        out_ready = 1'b1;
        send(32'd5, 1'b0); send(32'd7, 1'b0); send(32'd9, 1'b1);
        chk_result("sum3", 32'd21, 1'b0, 3'd3, 1'b0);
        step();
        out_ready = 1'b0;
        chk("sum3_release_ready", {63'd0, in_ready}, 64'd1);
        chk("sum3_release_valid", {63'd0, out_valid}, 64'd0);
        chk("sum3_release_sum", {32'd0, out_sum}, 64'd0);

        // Wrap-around, then held for 10 cycles with in_valid asserted
        send(32'hFFFF_FFFF, 1'b0); send(32'h0000_0002, 1'b1);
        chk_result("wrap", 32'h0000_0001, 1'b1, 3'd2, 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h0000_1234;
            in_last  = 1'b1;
            step();
            chk_result("hold", 32'h0000_0001, 1'b1, 3'd2, 1'b0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume();
        chk("hold_release_ready", {63'd0, in_ready}, 64'd1);
        chk("hold_release_ovf", {63'd0, out_ovf}, 64'd0);
        send(32'd3, 1'b1);
        chk_result("fresh", 32'd3, 1'b0, 3'd1, 1'b0);
        consume();

        // Single beat
        send(32'hDEAD_BEEF, 1'b1);
        chk_result("single", 32'hDEAD_BEEF, 1'b0, 3'd1, 1'b0);
        consume();

        // Counter saturation at 7 beats
        for (int k = 0; k < 7; k++) send(32'd1, 1'b0);
        chk_result("sat", 32'd7, 1'b0, 3'd7, 1'b1);
        out_ready = 1'b1;
        send(32'd1, 1'b0);
        out_ready = 1'b0;
        chk("sat_next_valid", {63'd0, out_valid}, 64'd0);
        chk("sat_next_count", {61'd0, out_count}, 64'd1);
        send(32'd1, 1'b1);
        chk_result("sat_next", 32'd2, 1'b0, 3'd2, 1'b0);
        consume();

        // Reset mid-packet
        send(32'd10, 1'b0); send(32'd20, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstmid_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid_sum", {32'd0, out_sum}, 64'd0);
        chk("rstmid_count", {61'd0, out_count}, 64'd0);
        send(32'd3, 1'b0); send(32'd4, 1'b1);
        chk_result("after_rst", 32'd7, 1'b0, 3'd2, 1'b0);

        // Reset while a result is held
        rst = 1'b1; step(); rst = 1'b0;
        chk("rsthold_valid", {63'd0, out_valid}, 64'd0);
        chk("rsthold_ready", {63'd0, in_ready}, 64'd1);
        chk("rsthold_sum", {32'd0, out_sum}, 64'd0);

        // Random beats and gaps against a reference model
        m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 9);
            for (int b = 0; b < len; b++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                if ($urandom_range(0, 2) == 0) d = 32'hFFFF_FF00 | $urandom_range(0, 255);
                else d = $urandom;
                last = (b == len - 1);
                send(d, last);
                wide  = {1'b0, m_acc} + {1'b0, d};
                m_acc = wide[31:0];
                m_ovf = m_ovf | wide[32];
                m_cnt = m_cnt + 3'd1;
                if (last || m_cnt == 3'd7) begin
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) step();
                    chk_result("rnd", m_acc, m_ovf, m_cnt, ~last);
                    consume();
                    m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rca_accumulator.md
Name: rca_accumulator

Overview:
- Sequential accumulation stage built around the existing ripple-carry adder `rca`.
- Accepts a stream of WIDTH-bit operands over a valid/ready handshake and sums one operand per cycle into a registered accumulator.
- Presents the total, a sticky carry-out/overflow flag and a beat count on a valid/ready output port.
- Sits between the operand source and the result consumer; it is the clocked stage that feeds the combinational adder and consumes its sum.

Parameters:
- WIDTH, 32, operand and accumulator width in bits.
- CNT_W, 8, width of the beat counter; maximum beats per packet = 2^CNT_W - 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  operand.
- in_last  in  1  final beat of the packet.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  accumulated sum, modulo 2^WIDTH.
- out_ovf  out  1  sticky: any addition in the packet produced carry-out.
- out_count  out  CNT_W  number of beats accepted in the packet.
- out_trunc  out  1  packet was closed by counter saturation, not by in_last.

Behaviour:
- Reset is synchronous, active-high, on one clock clk. In the cycle after rst is sampled high:
  - state = ACCUM; acc = 0; ovf = 0; count = 0; trunc = 0.
  - out_valid = 0; in_ready = 1.
- rst overrides everything. A reset asserted mid-packet or while a result is held discards all state, with no output.
- Adder: one `rca` instance with a = acc, b = in_data and carry input tied to 0. Result s[WIDTH:0]: s[WIDTH-1:0] is the next acc, and s[WIDTH] is the carry.
- FSM has two states.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - Accept condition is in_valid & in_ready. On accept: acc <= s[WIDTH-1:0]; ovf <= ovf | s[WIDTH]; count <= count + 1.
  - If in_last = 1 on the accepted beat, go to HOLD with trunc <= 0.
  - Otherwise, if count + 1 == 2^CNT_W - 1, go to HOLD with trunc <= 1.
  - If in_valid = 0, no change.
- HOLD:
  - in_ready = 0, out_valid = 1.
  - out_sum = acc, out_ovf = ovf, out_count = count, out_trunc = trunc; all are stable while out_valid = 1 and out_ready = 0.
  - When out_ready = 1: acc, ovf, count and trunc clear to 0, and the FSM returns to ACCUM. in_ready = 1 in the following cycle.
- Latency: a last beat accepted in cycle t gives out_valid = 1 in cycle t+1.
  - Minimum per-packet turnaround is N + 1 cycles for N beats: the HOLD cycle costs one bubble even with out_ready held at 1.
- Simultaneous events:
  - No input is accepted in HOLD, so out_ready and in_valid in the same cycle cannot collide.
  - in_ready depends only on state. There is no combinational path from out_ready or in_valid to in_ready.
- Single-beat packet (in_last on the first beat): out_sum = in_data, out_ovf = 0, out_count = 1.
- Wrap-around: the sum is taken modulo 2^WIDTH and out_ovf records it. The count never wraps, because saturation forces HOLD.
- Outputs are driven from registers and FSM state only. Nothing is driven combinationally from in_data.
- Formal properties:
  - out_valid & ~out_ready implies the outputs are stable in the next cycle.
  - in_ready and out_valid are never both 1.
  - After reset, out_valid = 0.

Decomposition:
- Shared package rca_pkg holds:
  - the state enum `acc_state_t {ACCUM, HOLD}`;
  - default width constants (RCA_WIDTH = 32, RCA_CNT_W = 8).
- One sub-module: the existing `rca`, instantiated once as the datapath adder.
- The FSM, counter and registers stay in rca_accumulator; no further split.

Test Plan:
- Reset, then beats 5, 7, 9 with in_last on 9, out_ready = 1 -> out_valid one cycle after beat 9; out_sum = 21, out_ovf = 0, out_count = 3, out_trunc = 0.
- WIDTH = 32: beats 0xFFFF_FFFF and 0x0000_0002 (last) -> out_sum = 0x0000_0001, out_ovf = 1, out_count = 2.
- Result held with out_ready = 0 for 10 cycles -> outputs unchanged, in_ready = 0 and in_valid ignored throughout. out_ready = 1 -> in_ready = 1 next cycle and the next packet starts from acc = 0.
- CNT_W = 3, eight beats of value 1 and no in_last -> HOLD after the 7th beat with out_count = 7, out_sum = 7, out_trunc = 1. The 8th beat is accepted as the first beat of the next packet.
- rst pulsed after 2 of 4 beats -> no out_valid. Next packet 3, 4 (last) -> out_sum = 7, out_count = 2.
- Random in_valid/out_ready gaps over 1000 packets -> each result equals the modulo-2^WIDTH sum of its beats, out_ovf matches the reference model, and no beat is lost or duplicated.
